ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX latch.
- Consumes its decoded control, operands, sign-extended immediate and rt/rd fields.
- Performs ALU control decode, ALU operation, branch-target add and destination-register select.
- Contains an iterative unsigned multiply/divide unit with HI/LO registers and a stall handshake.
- Registers all results into the EX/MEM boundary.

Parameters:
- XLEN, 32, datapath width. Also the number of mult/div iterations.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble).
- flush  in  1  synchronous kill of the current EX instruction.
- wb_ctl  in  2  WB control (bit1 RegWrite, bit0 MemtoReg), passed through.
- m_ctl  in  3  MEM control (Branch, MemRead, MemWrite), passed through.
- regdst  in  1  1 = destination is rd, 0 = destination is rt.
- alusrc  in  1  1 = operand B is s_extend, 0 = operand B is rdata2.
- aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or-immediate.
- npc  in  XLEN  PC+4.
- rdata1  in  XLEN  rs operand.
- rdata2  in  XLEN  rt operand.
- s_extend  in  XLEN  sign-extended immediate; funct = s_extend[5:0].
- instr_2016  in  5  rt field.
- instr_1511  in  5  rd field.
- stall  out  1  combinational; upstream must hold all inputs while high.
- ex_valid  out  1  registered valid.
- wb_ctlout  out  2  registered WB control.
- m_ctlout  out  3  registered MEM control.
- add_result  out  XLEN  registered branch target.
- zero  out  1  registered (alu_result == 0).
- alu_result  out  XLEN  registered ALU result.
- rdata2out  out  XLEN  registered store data.
- muxout  out  5  registered destination register.

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0, including stall.
  - HI and LO = 0; md FSM = IDLE; iteration counter = 0.
- Operand B = alusrc ? s_extend : rdata2.
- Register select: muxout = regdst ? instr_1511 : instr_2016.
- Branch target: add_result = npc + (s_extend << 2), modulo 2^XLEN.
- ALU ops:
  - aluop 00: A+B. aluop 01: A−B. aluop 11: A | {16'b0, s_extend[15:0]}.
  - aluop 10 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or: the matching op.
  - funct 0x2A slt: signed compare, result 1 or 0.
  - funct 0x10 mfhi: HI. funct 0x12 mflo: LO.
  - funct 0x18: multu. funct 0x1A: divu.
  - Any other funct: result 0.
  - All add/sub wrap; no overflow trap.
- Single-cycle ops: when in_valid and stall is low, all outputs are captured at the next rising edge (latency 1).
- Bubble (in_valid=0) or flush=1: next edge loads ex_valid=0, wb_ctlout=0, m_ctlout=0; data outputs don't-care, but are reset to 0.
- md FSM:
  - IDLE → BUSY when in_valid, aluop=10, funct is 0x18 or 0x1A, and flush=0.
    - stall=1 combinationally in that detect cycle.
    - Operands latch into the md unit; counter = XLEN.
  - BUSY: stall=1. One shift-add (mult) or restoring-subtract (div) step per cycle; counter decrements.
    - On the edge where the counter reaches 0, HI/LO are written and the FSM moves to DONE.
    - multu: {HI,LO} = A*B.
    - divu: LO = quotient, HI = remainder.
    - divu by zero: LO = all ones, HI = A, still XLEN cycles.
  - DONE: stall=0. The held instruction is captured into EX/MEM, alu_result=0. Next state IDLE; DONE never restarts an op.
  - Total: stall high XLEN+1 cycles (33 by default), EX/MEM loaded at the end of cycle XLEN+2.
- flush during BUSY:
  - Abort to IDLE next edge; HI/LO unchanged; stall drops after that edge.
  - EX/MEM loads a bubble.
- mfhi/mflo following a mult/div needs no interlock: the completed values are visible in DONE and later.
- Back-to-back mult/div: the second is detected only once the FSM is in IDLE.

Decomposition:
- Shared package ex_pkg holds:
  - aluop encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ORI).
  - funct constants (FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, FUNCT_MULTU, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO).
  - md FSM state enum (MD_IDLE, MD_BUSY, MD_DONE).
- One sub-module md_unit: iterative multiply/divide datapath plus counter.
  - Interface: start, op, a, b, abort; outputs busy, done, hi, lo.
- ALU, muxes and the EX/MEM register stay in ex_stage.

Test Plan:
- Reset with inputs non-zero, rst_n low mid-cycle → all outputs 0 immediately; HI=LO=0.
- aluop=10, funct 0x22, rdata1=5, rdata2=7, in_valid=1 → next edge alu_result=0xFFFFFFFE, zero=0, muxout=instr_1511.
- aluop=01, rdata1=rdata2=0x1234, npc=0x100, s_extend=0xFFFFFFFF → zero=1, add_result=0xFC.
- multu A=0xFFFFFFFF, B=2 → stall high 33 cycles, then HI=1, LO=0xFFFFFFFE; following mfhi yields 1.
- divu A=100, B=0 → LO=0xFFFFFFFF, HI=100 after 33 stall cycles; divu 100/7 → LO=14, HI=2.
- flush at BUSY cycle 10 of multu → FSM IDLE, stall low after next edge, HI/LO keep prior values, ex_valid=0.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the MIPS execute stage: ALU op selects, R-type funct codes
// and the multiply/divide sequencer states.
package ex_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ORI   = 2'b11;

   localparam logic [5:0] FUNCT_ADD   = 6'h20;
   localparam logic [5:0] FUNCT_SUB   = 6'h22;
   localparam logic [5:0] FUNCT_AND   = 6'h24;
   localparam logic [5:0] FUNCT_OR    = 6'h25;
   localparam logic [5:0] FUNCT_SLT   = 6'h2A;
   localparam logic [5:0] FUNCT_MULTU = 6'h18;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1A;
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic is_md_funct(input logic [5:0] funct);
      return (funct == FUNCT_MULTU) || (funct == FUNCT_DIVU);
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; master is the upstream/downstream pipeline,
// slave is the execute stage itself.
interface ex_stage_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            flush;
   logic [1:0]      wb_ctl;
   logic [2:0]      m_ctl;
   logic            regdst;
   logic            alusrc;
   logic [1:0]      aluop;
   logic [XLEN-1:0] npc;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic [XLEN-1:0] s_extend;
   logic [4:0]      instr_2016;
   logic [4:0]      instr_1511;
   logic            stall;
   logic            ex_valid;
   logic [1:0]      wb_ctlout;
   logic [2:0]      m_ctlout;
   logic [XLEN-1:0] add_result;
   logic            zero;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] rdata2out;
   logic [4:0]      muxout;

   modport master (
      output in_valid, flush, wb_ctl, m_ctl, regdst, alusrc, aluop, npc,
             rdata1, rdata2, s_extend, instr_2016, instr_1511,
      input  stall, ex_valid, wb_ctlout, m_ctlout, add_result, zero,
             alu_result, rdata2out, muxout
   );

   modport slave (
      input  in_valid, flush, wb_ctl, m_ctl, regdst, alusrc, aluop, npc,
             rdata1, rdata2, s_extend, instr_2016, instr_1511,
      output stall, ex_valid, wb_ctlout, m_ctlout, add_result, zero,
             alu_result, rdata2out, muxout
   );
endinterface

// File: rtl/ex_stage_md_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per
// cycle, XLEN cycles per operation, owning the architectural HI/LO registers.
module md_unit
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);
   localparam int CW = $clog2(XLEN + 1);

   md_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            op_q, op_d;
   logic [XLEN-1:0] b_q, b_d, wh_q, wh_d, wl_q, wl_d, hi_q, hi_d, lo_q, lo_d;
   logic [XLEN:0]   sum_s, shift_s, diff_s;
   logic [XLEN-1:0] step_hi_s, step_lo_s;

   // One iteration: op 0 = multiply step, op 1 = divide step.
   always_comb begin
      sum_s   = {1'b0, wh_q} + {1'b0, (wl_q[0] ? b_q : {XLEN{1'b0}})};
      shift_s = {wh_q, wl_q[XLEN-1]};
      diff_s  = shift_s - {1'b0, b_q};
      if (op_q == 1'b0) begin
         step_hi_s = sum_s[XLEN:1];
         step_lo_s = {sum_s[0], wl_q[XLEN-1:1]};
      end else if (diff_s[XLEN] == 1'b0) begin
         step_hi_s = diff_s[XLEN-1:0];
         step_lo_s = {wl_q[XLEN-2:0], 1'b1};
      end else begin
         step_hi_s = shift_s[XLEN-1:0];
         step_lo_s = {wl_q[XLEN-2:0], 1'b0};
      end
   end

   // Sequencer next state; a zero divisor simply yields all-ones quotient and A as remainder.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      b_d     = b_q;
      wh_d    = wh_q;
      wl_d    = wl_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_BUSY;
               cnt_d   = CW'(XLEN);
               op_d    = op;
               b_d     = b;
               wh_d    = {XLEN{1'b0}};
               wl_d    = a;
            end else begin
               state_d = MD_IDLE;
            end
         end
         MD_BUSY: begin
            if (abort) begin
               state_d = MD_IDLE;
               cnt_d   = {CW{1'b0}};
            end else begin
               wh_d  = step_hi_s;
               wl_d  = step_lo_s;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  hi_d    = step_hi_s;
                  lo_d    = step_lo_s;
                  state_d = MD_DONE;
               end else begin
                  state_d = MD_BUSY;
               end
            end
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   // Sequencer and HI/LO state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
         cnt_q   <= {CW{1'b0}};
         op_q    <= 1'b0;
         b_q     <= {XLEN{1'b0}};
         wh_q    <= {XLEN{1'b0}};
         wl_q    <= {XLEN{1'b0}};
         hi_q    <= {XLEN{1'b0}};
         lo_q    <= {XLEN{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         b_q     <= b_d;
         wh_q    <= wh_d;
         wl_q    <= wl_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == MD_BUSY);
   assign done = (state_q == MD_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch-target adder, destination select, mult/div
// sequencing with upstream stall, and the EX/MEM pipeline register.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   ex_stage_if.slave  bus
);
   logic [5:0]      funct_s;
   logic [XLEN-1:0] op_b_s, alu_s, md_hi_s, md_lo_s;
   logic            md_busy_s, md_done_s, md_idle_s, start_req_s, stall_s, capture_s;

   logic            ex_valid_q, ex_valid_d, zero_q, zero_d;
   logic [1:0]      wb_q, wb_d;
   logic [2:0]      m_q, m_d;
   logic [XLEN-1:0] add_q, add_d, alu_q, alu_d, rd2_q, rd2_d;
   logic [4:0]      mux_q, mux_d;

   assign funct_s     = bus.s_extend[5:0];
   assign op_b_s      = bus.alusrc ? bus.s_extend : bus.rdata2;
   assign md_idle_s   = !md_busy_s && !md_done_s;
   assign start_req_s = bus.in_valid && !bus.flush && (bus.aluop == ALUOP_RTYPE) && is_md_funct(funct_s);
   // Stall covers the detect cycle plus every busy cycle; forced low while in reset.
   assign stall_s     = rst_n && (md_busy_s || (md_idle_s && start_req_s));
   assign capture_s   = bus.in_valid && !bus.flush && !stall_s;

   md_unit #(.XLEN(XLEN)) u_md (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_req_s),
      .op    (funct_s == FUNCT_DIVU),
      .a     (bus.rdata1),
      .b     (bus.rdata2),
      .abort (bus.flush),
      .busy  (md_busy_s),
      .done  (md_done_s),
      .hi    (md_hi_s),
      .lo    (md_lo_s)
   );

   // ALU; multu/divu fall into the default and therefore report zero.
   always_comb begin
      alu_s = {XLEN{1'b0}};
      case (bus.aluop)
         ALUOP_ADD: alu_s = bus.rdata1 + op_b_s;
         ALUOP_SUB: alu_s = bus.rdata1 - op_b_s;
         ALUOP_ORI: alu_s = bus.rdata1 | {{(XLEN-16){1'b0}}, bus.s_extend[15:0]};
         ALUOP_RTYPE: begin
            case (funct_s)
               FUNCT_ADD:  alu_s = bus.rdata1 + op_b_s;
               FUNCT_SUB:  alu_s = bus.rdata1 - op_b_s;
               FUNCT_AND:  alu_s = bus.rdata1 & op_b_s;
               FUNCT_OR:   alu_s = bus.rdata1 | op_b_s;
               FUNCT_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(bus.rdata1) < $signed(op_b_s))};
               FUNCT_MFHI: alu_s = md_hi_s;
               FUNCT_MFLO: alu_s = md_lo_s;
               default:    alu_s = {XLEN{1'b0}};
            endcase
         end
         default: alu_s = {XLEN{1'b0}};
      endcase
   end

   // EX/MEM next values: bubbles and stalled cycles load all zeros.
   always_comb begin
      if (capture_s) begin
         ex_valid_d = 1'b1;
         wb_d       = bus.wb_ctl;
         m_d        = bus.m_ctl;
         add_d      = bus.npc + {bus.s_extend[XLEN-3:0], 2'b00};
         alu_d      = alu_s;
         zero_d     = (alu_s == {XLEN{1'b0}});
         rd2_d      = bus.rdata2;
         mux_d      = bus.regdst ? bus.instr_1511 : bus.instr_2016;
      end else begin
         ex_valid_d = 1'b0;
         wb_d       = 2'b00;
         m_d        = 3'b000;
         add_d      = {XLEN{1'b0}};
         alu_d      = {XLEN{1'b0}};
         zero_d     = 1'b0;
         rd2_d      = {XLEN{1'b0}};
         mux_d      = 5'd0;
      end
   end

   // EX/MEM pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         wb_q       <= 2'b00;
         m_q        <= 3'b000;
         add_q      <= {XLEN{1'b0}};
         alu_q      <= {XLEN{1'b0}};
         zero_q     <= 1'b0;
         rd2_q      <= {XLEN{1'b0}};
         mux_q      <= 5'd0;
      end else begin
         ex_valid_q <= ex_valid_d;
         wb_q       <= wb_d;
         m_q        <= m_d;
         add_q      <= add_d;
         alu_q      <= alu_d;
         zero_q     <= zero_d;
         rd2_q      <= rd2_d;
         mux_q      <= mux_d;
      end
   end

   assign bus.stall      = stall_s;
   assign bus.ex_valid   = ex_valid_q;
   assign bus.wb_ctlout  = wb_q;
   assign bus.m_ctlout   = m_q;
   assign bus.add_result = add_q;
   assign bus.zero       = zero_q;
   assign bus.alu_result = alu_q;
   assign bus.rdata2out  = rd2_q;
   assign bus.muxout     = mux_q;
endmodule
